bitonic_loader: RTL

Input loader sitting directly upstream of the first bitonic sorting stage. It accepts a stream of WIDTH-bit words over a valid/ready handshake and assembles them into DEPTH-word frames. It presents each complete frame in parallel to `stage1` over a frame-level valid/ready handshake. Two ping-pong banks let one frame be filled while the other waits to be consumed, so an unstalled stream runs at one word per cycle.

---
 rtl/bitonic_pkg.sv | 23 ++
 rtl/bitonic_loader_if.sv | 46 ++++
 rtl/bitonic_load_bank.sv | 61 ++++++
 rtl/bitonic_loader.sv | 94 +++++++++
 4 files changed

// File: rtl/bitonic_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bitonic_pkg                                                           |
// | Shared types and defaults for the bitonic sorter input loader.        |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package bitonic_pkg;

   localparam int BITONIC_WIDTH = 32;
   localparam int BITONIC_DEPTH = 8;

   typedef logic [0:BITONIC_WIDTH-1] word_t;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } bank_state_e;

   // All ones, so padded slots sort to the tail of an ascending sort.
   localparam word_t PAD_VALUE = '1;

endpackage
`default_nettype wire

// File: rtl/bitonic_loader_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bitonic_loader_if                                                     |
// | Word-stream input and frame-output handshakes of the loader.          |
// | Optional: BITONIC_LOADER_PAD_EN adds in_last.                         |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface bitonic_loader_if
   import bitonic_pkg::*;
#(
   parameter int WIDTH = BITONIC_WIDTH,
   parameter int DEPTH = BITONIC_DEPTH
);

   logic             in_valid;
   logic             in_ready;
   logic [0:WIDTH-1] in_data;
`ifdef BITONIC_LOADER_PAD_EN
   logic             in_last;
`endif
   logic             frame_valid;
   logic             frame_ready;
   logic [0:WIDTH-1] frame_data [0:DEPTH-1];

`ifdef BITONIC_LOADER_PAD_EN
   modport master (
      output in_valid, in_data, in_last, frame_ready,
      input  in_ready, frame_valid, frame_data
   );
   modport slave (
      input  in_valid, in_data, in_last, frame_ready,
      output in_ready, frame_valid, frame_data
   );
`else
   modport master (
      output in_valid, in_data, frame_ready,
      input  in_ready, frame_valid, frame_data
   );
   modport slave (
      input  in_valid, in_data, frame_ready,
      output in_ready, frame_valid, frame_data
   );
`endif

endinterface
`default_nettype wire

// File: rtl/bitonic_load_bank.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bitonic_load_bank                                                     |
// | One DEPTH x WIDTH frame register with indexed write, pad-fill of the  |
// | slots above the write index, and an EMPTY/FULL flag.                  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module bitonic_load_bank
   import bitonic_pkg::*;
#(
   parameter int WIDTH = BITONIC_WIDTH,
   parameter int DEPTH = BITONIC_DEPTH,
   parameter int IDX_W = $clog2(DEPTH)
)
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_we,
   input  logic [IDX_W-1:0]            i_idx,
   input  logic [0:WIDTH-1]            i_data,
   input  logic                        i_pad,
   input  logic                        i_close,
   input  logic                        i_free,
   output logic                        o_full,
   output logic [0:DEPTH-1][0:WIDTH-1] o_data
);

   localparam logic [0:WIDTH-1] c_pad = '1;

   bank_state_e                 r_state;
   logic [0:DEPTH-1][0:WIDTH-1] r_mem;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= EMPTY;
         r_mem   <= '0;
      end else begin
         if (i_we) begin
            r_mem[i_idx] <= i_data;
         end
         if (i_pad) begin
            for (int j = 0; j < DEPTH; j++) begin
               if (j > int'(i_idx)) begin
                  r_mem[j] <= c_pad;
               end
            end
         end
         // Close and free never target the same bank in one cycle.
         if (i_close) begin
            r_state <= FULL;
         end else if (i_free) begin
            r_state <= EMPTY;
         end
      end
   end

   assign o_full = (r_state == FULL);
   assign o_data = r_mem;

endmodule
`default_nettype wire

// File: rtl/bitonic_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bitonic_loader                                                        |
// | Ping-pong frame assembler feeding the first bitonic sorting stage.    |
// | Optional: BITONIC_LOADER_PAD_EN enables in_last short-frame padding.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module bitonic_loader
   import bitonic_pkg::*;
#(
   parameter int WIDTH = BITONIC_WIDTH,
   parameter int DEPTH = BITONIC_DEPTH
)
(
   input logic            clk,
   input logic            rst,
   bitonic_loader_if.slave bus
);

   localparam int               IDX_W      = $clog2(DEPTH);
   localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(DEPTH - 1);

   logic                        r_wr_bank;
   logic                        r_rd_bank;
   logic [IDX_W-1:0]            r_wr_idx;

   logic [1:0]                  w_full;
   logic [0:DEPTH-1][0:WIDTH-1] w_bank_data [0:1];
   logic                        w_word_acc;
   logic                        w_frame_acc;
   logic                        w_pad;
   logic                        w_last;

`ifdef BITONIC_LOADER_PAD_EN
   assign w_pad = bus.in_last;
`else
   assign w_pad = 1'b0;
`endif

   assign w_last          = (r_wr_idx == c_last_idx) || w_pad;
   // in_ready depends only on registered bank state, never on frame_ready.
   assign bus.in_ready    = !w_full[r_wr_bank] && !rst;
   assign bus.frame_valid = w_full[r_rd_bank];
   assign w_word_acc      = bus.in_valid && bus.in_ready;
   assign w_frame_acc     = bus.frame_valid && bus.frame_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_bank <= 1'b0;
         r_rd_bank <= 1'b0;
         r_wr_idx  <= '0;
      end else begin
         if (w_word_acc) begin
            if (w_last) begin
               r_wr_idx  <= '0;
               r_wr_bank <= ~r_wr_bank;
            end else begin
               r_wr_idx  <= r_wr_idx + 1'b1;
            end
         end
         if (w_frame_acc) begin
            r_rd_bank <= ~r_rd_bank;
         end
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_bank
      logic w_we;
      assign w_we = w_word_acc && (r_wr_bank == 1'(g));

      bitonic_load_bank #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH),
         .IDX_W (IDX_W)
      ) u_bank (
         .clk     (clk),
         .rst     (rst),
         .i_we    (w_we),
         .i_idx   (r_wr_idx),
         .i_data  (bus.in_data),
         .i_pad   (w_we && w_pad),
         .i_close (w_we && w_last),
         .i_free  (w_frame_acc && (r_rd_bank == 1'(g))),
         .o_full  (w_full[g]),
         .o_data  (w_bank_data[g])
      );
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_frame
      assign bus.frame_data[k] = w_bank_data[r_rd_bank][k];
   end

endmodule
`default_nettype wire
